// File: rtl/sw_pkg.sv
// Shared types and constants for the switch debouncer.
// Holds the per-channel FSM state type and the default debounce period.
package sw_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int DEFAULT_CNT_MAX = 1000000;

    // Counter width for a given period; never below one bit.
    function automatic int cnt_width(input int cnt_max);
        int w;
        w = $clog2(cnt_max);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, IDLE/COUNT FSM, run counter.
// Edge pulse registers exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_chan
    import sw_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int W = cnt_width(CNT_MAX);
    localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);

    logic         sync1;
    logic         s;
    state_t       state;
    state_t       state_n;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_n;
    logic         clean_n;

    // Synchronizer, FSM state, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            s        <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            sw_clean <= 1'b0;
        end else begin
            sync1    <= sw;
            s        <= sync1;
            state    <= state_n;
            cnt      <= cnt_n;
            sw_clean <= clean_n;
        end
    end

    // Next state: count a run of the new level, drop back on any bounce.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clean_n = sw_clean;
        unique case (state)
            IDLE: begin
                if (s != sw_clean) begin
                    state_n = COUNT;
                    cnt_n   = W'(1);
                end else begin
                    cnt_n = '0;
                end
            end
            COUNT: begin
                if (s == sw_clean) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clean_n = s;
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // One-cycle pulses, aligned with the sw_clean update.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= clean_n & ~sw_clean;
            sw_fall <= ~clean_n & sw_clean;
        end
    end
`else
    assign sw_rise = 1'b0;
    assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: N_SW independent channels.
// Edge outputs are live only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW    = 3,
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_changed
);

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        sw_debounce_chan #(
            .CNT_MAX(CNT_MAX)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .sw      (sw[i]),
            .sw_clean(sw_clean[i]),
            .sw_rise (sw_rise[i]),
            .sw_fall (sw_fall[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    assign sw_changed = |(sw_rise | sw_fall);
`else
    assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (N_SW=3, CNT_MAX=4).
// A window-based reference model feeds a per-cycle expected-value queue.
module tb_sw_debounce;

    localparam int N  = 3;
    localparam int CM = 4;
    localparam int WD = 3 * N + 1;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif
    localparam logic [N-1:0] ENM = (E != 0) ? '1 : '0;

    logic         clk;
    logic         reset;
    logic [N-1:0] sw;
    logic [N-1:0] sw_clean;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_changed;

    int n_checks = 0;
    int n_fail   = 0;
    int n_chg    = 0;
    int c0;

    logic [WD-1:0] exp_q [$];

    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic [N-1:0] m_clean;
    logic [N-1:0] m_hist [CM];

    sw_debounce #(
        .N_SW   (N),
        .CNT_MAX(CM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Reference: a channel flips once its last CM synced samples all
    // differ from the current clean level.
    always @(posedge clk) begin : model
        logic [N-1:0] h [CM];
        logic [N-1:0] nc;
        logic [N-1:0] r;
        logic [N-1:0] f;
        logic         all;
        if (reset) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_clean <= '0;
            for (int j = 0; j < CM; j++) m_hist[j] <= '0;
            exp_q.push_back('0);
        end else begin
            h[0] = m_s2;
            for (int j = 1; j < CM; j++) h[j] = m_hist[j-1];
            nc = m_clean;
            r  = '0;
            f  = '0;
            for (int i = 0; i < N; i++) begin
                all = 1'b1;
                for (int j = 0; j < CM; j++)
                    if (h[j][i] == m_clean[i]) all = 1'b0;
                if (all) begin
                    nc[i] = ~m_clean[i];
                    r[i]  = nc[i];
                    f[i]  = m_clean[i];
                end
            end
            m_s1    <= sw;
            m_s2    <= m_s1;
            m_clean <= nc;
            for (int j = 0; j < CM; j++) m_hist[j] <= h[j];
            exp_q.push_back({nc, r & ENM, f & ENM,
                             (|(r | f)) & (E != 0)});
        end
    end

    // Pop one expected word per cycle and compare away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check("cycle", 32'({sw_clean, sw_rise, sw_fall, sw_changed}),
                  32'(exp_q.pop_front()));
        if (sw_changed) n_chg++;
    end

    initial begin
        reset = 1'b1;
        sw    = '0;
        repeat (3) @(negedge clk);
        check("rst_clean", 32'(sw_clean), 0);
        check("rst_pulse", 32'({sw_rise, sw_fall, sw_changed}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // clean step on channel 0
        c0 = n_chg;
        sw = 3'b001;
        repeat (5) @(negedge clk);
        check("s1_pre", 32'(sw_clean), 0);
        @(negedge clk);
        check("s1_clean", 32'(sw_clean), 32'(3'b001));
        check("s1_rise", 32'(sw_rise), 32'(3'b001 & ENM));
        check("s1_chg", 32'(sw_changed), E);
        @(negedge clk);
        check("s1_rise_off", 32'(sw_rise), 0);
        repeat (6) @(negedge clk);
        check("s1_nchg", 32'(n_chg - c0), E);
        sw = 3'b000;
        repeat (12) @(negedge clk);

        // bounce on channel 0
        c0 = n_chg;
        sw = 3'b001;
        @(negedge clk);
        sw = 3'b000;
        @(negedge clk);
        sw = 3'b001;
        @(negedge clk);
        sw = 3'b000;
        repeat (12) @(negedge clk);
        check("s2_clean", 32'(sw_clean), 0);
        check("s2_nchg", 32'(n_chg - c0), 0);

        // simultaneous rise, then mixed fall
        c0 = n_chg;
        sw = 3'b111;
        repeat (6) @(negedge clk);
        check("s3_clean", 32'(sw_clean), 32'(3'b111));
        check("s3_rise", 32'(sw_rise), 32'(3'b111 & ENM));
        repeat (6) @(negedge clk);
        check("s3_nchg", 32'(n_chg - c0), E);
        sw = 3'b010;
        repeat (5) @(negedge clk);
        check("s3_fpre", 32'(sw_clean), 32'(3'b111));
        @(negedge clk);
        check("s3_fclean", 32'(sw_clean), 32'(3'b010));
        check("s3_fall", 32'(sw_fall), 32'(3'b101 & ENM));
        check("s3_frise", 32'(sw_rise), 0);
        repeat (6) @(negedge clk);
        sw = 3'b000;
        repeat (12) @(negedge clk);

        // reset mid-count on channel 2
        c0 = n_chg;
        sw = 3'b100;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s4_rst", 32'(sw_clean), 0);
        repeat (5) @(negedge clk);
        check("s4_nopulse", 32'(sw_clean), 0);
        check("s4_nchg", 32'(n_chg - c0), 0);
        @(negedge clk);
        check("s4_clean", 32'(sw_clean), 32'(3'b100));
        check("s4_rise", 32'(sw_rise), 32'(3'b100 & ENM));
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
